// File: rtl/sub16_seq_sub.sv
// sub16_seq_sub: sequential 16-bit subtractor (x - y) built from a slice-serial adder.
// Latency: done 4 cycles after the start edge (2 cycles when SUB16_BYTE_STEP_EN is defined).
// Backpressure: none; start is only honoured in IDLE, and a start seen in RUN or DONE is dropped.
// Config macro SUB16_BYTE_STEP_EN: 8-bit slices (2 RUN cycles) instead of 4-bit slices (4 RUN cycles).
module sub16_seq_sub (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [15:0] z,
  output logic        borrow,
  output logic        zero,
  output logic        parity,
  output logic        sign,
  output logic        overflow,
  output logic        busy,
  output logic        done
);

`ifdef SUB16_BYTE_STEP_EN
  localparam int SW = 8;
`else
  localparam int SW = 4;
`endif
  localparam int         STEPS     = 16 / SW;
  localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [15:0] acc_q, acc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        carry_q, carry_d;
  logic [15:0] z_q, z_d;
  logic        borrow_q, borrow_d;
  logic        zero_q, zero_d;
  logic        parity_q, parity_d;
  logic        sign_q, sign_d;
  logic        overflow_q, overflow_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [SW-1:0] x_slice, y_slice;
  logic [SW:0]   slice_sum;
  logic [15:0]   acc_nxt;
  logic          last_step;

  // Slice adder, next-state and result/flag capture on the final slice.
  always_comb begin
    x_slice    = x_q[cnt_q*SW +: SW];
    y_slice    = y_q[cnt_q*SW +: SW];
    // Subtraction as x + ~y + 1: the initial carry-in of 1 supplies the +1.
    slice_sum  = {1'b0, x_slice} + {1'b0, ~y_slice} + {{SW{1'b0}}, carry_q};
    acc_nxt    = acc_q;
    acc_nxt[cnt_q*SW +: SW] = slice_sum[SW-1:0];
    last_step  = (cnt_q == LAST_STEP);

    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    z_d        = z_q;
    borrow_d   = borrow_q;
    zero_d     = zero_q;
    parity_d   = parity_q;
    sign_d     = sign_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x;
          y_d     = y;
          acc_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_nxt;
        carry_d = slice_sum[SW];
        cnt_d   = last_step ? 2'd0 : cnt_q + 2'd1;
        if (last_step) begin
          // Result and flags move together so z never shows a partial difference.
          z_d        = acc_nxt;
          borrow_d   = ~slice_sum[SW];
          zero_d     = ~|acc_nxt;
          parity_d   = ~^acc_nxt;
          sign_d     = acc_nxt[15];
          overflow_d = (x_q[15] & ~y_q[15] & ~acc_nxt[15]) |
                       (~x_q[15] & y_q[15] & acc_nxt[15]);
          state_d    = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      z_q        <= '0;
      borrow_q   <= 1'b0;
      zero_q     <= 1'b0;
      parity_q   <= 1'b0;
      sign_q     <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      z_q        <= z_d;
      borrow_q   <= borrow_d;
      zero_q     <= zero_d;
      parity_q   <= parity_d;
      sign_q     <= sign_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign z        = z_q;
  assign borrow   = borrow_q;
  assign zero     = zero_q;
  assign parity   = parity_q;
  assign sign     = sign_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sub16_seq_sub.sv
// Bench for sub16_seq_sub: a driver pushes the expected result and due cycle for every
// start it knows will be accepted, and a negedge monitor checks done, busy and the held
// result against that queue; reset flushes the queue and expects all outputs at zero.
module tb_sub16_seq_sub;

`ifdef SUB16_BYTE_STEP_EN
  localparam int STEPS = 2;
`else
  localparam int STEPS = 4;
`endif

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] x, y, z;
  logic        borrow, zero, parity, sign, overflow, busy, done;

  sub16_seq_sub dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .z(z),
    .borrow(borrow), .zero(zero), .parity(parity), .sign(sign),
    .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] z;
    logic        borrow, zero, parity, sign, ovf;
  } res_t;

  typedef struct {
    int   due;
    res_t r;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on the operands.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
    res_t r;
    int   d;
    r.z      = a - b;
    r.borrow = (a < b);
    r.zero   = (r.z == 16'h0000);
    r.parity = (($countones(r.z) % 2) == 0);
    r.sign   = r.z[15];
    d        = int'($signed(a)) - int'($signed(b));
    r.ovf    = (d > 32767) || (d < -32768);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: every negedge compare done/busy/result with what the queue predicts.
  logic rst_prev = 1'b0;
  res_t hold = '0;
  always @(negedge clk) begin
    res_t act;
    logic dexp, bexp;
    act = {z, borrow, zero, parity, sign, overflow};
    dexp = 1'b0;
    bexp = 1'b0;
    if (rst_prev) begin
      sb.delete();
      hold = '0;
    end else if (sb.size() > 0) begin
      dexp = (sb[0].due == cyc);
      bexp = (cyc >= sb[0].due - STEPS) && (cyc < sb[0].due);
      if (dexp) begin
        hold = sb[0].r;
        void'(sb.pop_front());
      end
    end
    chk("done", {31'b0, done}, {31'b0, dexp});
    chk("busy", {31'b0, busy}, {31'b0, bexp});
    chk("result", {11'b0, act}, {11'b0, hold});
    rst_prev = rst;
  end

  // One accepted operation, followed by junk on the inputs while the DUT is busy.
  task automatic op(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    start = 1'b1;
    x     = a;
    y     = b;
    @(posedge clk); #1;
    e.due = cyc + STEPS;
    e.r   = model(a, b);
    sb.push_back(e);
    for (int i = 0; i <= STEPS; i++) begin
      start = 1'($urandom_range(0, 1));
      x     = 16'($urandom);
      y     = 16'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst   = 1'b1;
    start = 1'b0;
    x     = '0;
    y     = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    op(16'h0005, 16'h0003);
    op(16'h0003, 16'h0005);
    op(16'h8000, 16'h0001);
    op(16'h1234, 16'h1234);
    op(16'h0100, 16'h0001);
    op(16'h7FFF, 16'hFFFF);
    op(16'h0000, 16'h0000);

    // Abort: start, ignored second start, then reset during the third RUN cycle.
    start = 1'b1; x = 16'hFFFF; y = 16'h0001;
    @(posedge clk); #1;
    e.due = cyc + STEPS;
    e.r   = model(16'hFFFF, 16'h0001);
    sb.push_back(e);
    start = 1'b1; x = 16'h0001; y = 16'h0001;
    @(posedge clk); #1;
    start = 1'b0;
`ifndef SUB16_BYTE_STEP_EN
    @(posedge clk); #1;
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    op(16'h0010, 16'h0001);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        start = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
      op(16'($urandom), 16'($urandom));
    end

    start = 1'b0;
    repeat (STEPS + 4) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sub16_seq_sub.md
SUB16_SEQ_SUB -- requirements
Module: sub16_seq_sub

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; no other clocks or asynchronous inputs.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 x  input  16  minuend; sampled with start.
REQ-006 y  input  16  subtrahend; sampled with start.
REQ-007 z  output  16  registered difference x - y mod 2^16.
REQ-008 borrow  output  1  1 when unsigned x < y.
REQ-009 zero  output  1  1 when z == 0.
REQ-010 parity  output  1  even-parity flag: 1 when z has an even number of ones.
REQ-011 sign  output  1  equals z[15].
REQ-012 overflow  output  1  two's-complement overflow of x - y.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 IDLE with start=1 SHALL latch x and y, clear the step counter, set carry-in to 1, and move to RUN.
REQ-017 Each RUN cycle SHALL compute one 4-bit slice as x_slice + ~y_slice + carry, least significant slice first, and store the slice sum and carry-out internally.
REQ-018 Slice carry SHALL ripple across cycles through a 1-bit carry register.
REQ-019 After the 4th slice, on the same edge, the block SHALL load z and all flags and move to DONE.
REQ-020 done SHALL be high exactly 4 cycles after the edge that sampled start; DONE SHALL return to IDLE on the next edge, with done dropping to 0.
REQ-021 The flag equations SHALL be: borrow = NOT final carry-out; zero = NOR of z; parity = XNOR of z; sign = z[15]; overflow = (x15 & ~y15 & ~z15) | (~x15 & y15 & z15), using the latched operands.
REQ-022 z and the flags SHALL change only on the completion edge and SHALL hold the previous result during RUN and until the next completion.
REQ-023 start asserted in RUN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-024 Changes on x and y after the start sample SHALL NOT affect the result.
REQ-025 Back-to-back operation SHALL be supported: start held high re-triggers on the first IDLE cycle after DONE.

Reset
REQ-026 rst SHALL take priority over all other inputs in every state and force the FSM to IDLE.
REQ-027 In reset, z SHALL be 0, borrow, zero, parity, sign, overflow, busy and done SHALL all be 0, and the internal carry, counter and operand registers SHALL be cleared.
REQ-028 rst asserted in the middle of RUN SHALL abort the operation, produce no done pulse, and leave no partial result on z.

Configuration
REQ-029 The macro SUB16_BYTE_STEP_EN SHALL select the slice width.
REQ-030 With SUB16_BYTE_STEP_EN defined, slices SHALL be 8 bits, RUN SHALL last 2 cycles, and done SHALL be high 2 cycles after the start edge.
REQ-031 Without SUB16_BYTE_STEP_EN, slices SHALL be 4 bits and RUN SHALL last 4 cycles.
REQ-032 The ports, the flag semantics and the reset behaviour SHALL be identical in both builds.

Verification
REQ-033 x=0x0005, y=0x0003, start -> after 4 clocks done=1, z=0x0002, borrow=0, zero=0, parity=0, sign=0, overflow=0; busy high for exactly 4 cycles.
REQ-034 x=0x0003, y=0x0005 -> z=0xFFFE, borrow=1, sign=1, parity=0, overflow=0.
REQ-035 x=0x8000, y=0x0001 -> z=0x7FFF, overflow=1, borrow=0, sign=0, parity=0.
REQ-036 x=0x1234, y=0x1234 -> z=0x0000, zero=1, parity=1, borrow=0, overflow=0.
REQ-037 Start 0xFFFF-0x0001, then a second start with 0x0001-0x0001 during RUN, then rst on RUN cycle 3 -> no done pulse, all outputs 0; a following 0x0010-0x0001 -> z=0x000F 4 clocks after start.
REQ-038 Build with SUB16_BYTE_STEP_EN, x=0x0100, y=0x0001 -> done 2 clocks after start, z=0x00FF, parity=1, borrow=0.
